// File: rtl/hzd_scoreboard_pkg.sv
// hzd_scoreboard_pkg: shared register-address and forwarding-source types for the hazard scoreboard
package hzd_scoreboard_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam int MAX_XLEN = 64;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef struct packed {
    logic valid;
    reg_addr_t rd;
    logic rdy;
    logic [MAX_XLEN-1:0] data;
  } byp_src_t;
endpackage

// File: rtl/hzd_byp_sel.sv
// hzd_byp_sel: per-operand priority match across forwarding sources and writeback, with hazard detection
module hzd_byp_sel
  import hzd_scoreboard_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_BYP = 3
) (
  input  reg_addr_t                  rs,
  input  logic                       use_rs,
  input  logic                       cnt_nz,
  input  byp_src_t [NUM_BYP-1:0]     byp,
  input  byp_src_t                   wb,
  output logic                       fwd_valid,
  output logic [XLEN-1:0]            fwd_data,
  output logic                       hazard
);
  logic live, hit, rdy;
  logic [MAX_XLEN-1:0] data;
  assign live = use_rs && rs != '0;
  // Scan oldest to youngest so the youngest matching stage overrides everything older.
  always_comb begin
    hit = live && wb.valid && wb.rd == rs;
    rdy = wb.rdy;
    data = wb.data;
    for (int i = NUM_BYP - 1; i >= 0; i--) begin
      if (live && byp[i].valid && byp[i].rd == rs) begin
        hit = 1'b1;
        rdy = byp[i].rdy;
        data = byp[i].data;
      end
    end
  end
  assign fwd_valid = hit && rdy;
  assign fwd_data = fwd_valid ? data[XLEN-1:0] : '0;
  assign hazard = live && (hit ? !rdy : cnt_nz);
endmodule

// File: rtl/hzd_scoreboard.sv
// hzd_scoreboard: pending-write scoreboard with forwarding and valid/ready issue gating
// Optional: HZD_PERF_CNT_EN adds stall_cnt/stall_clr stall-cycle performance counter.
module hzd_scoreboard
  import hzd_scoreboard_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_BYP = 3,
  parameter int CNT_W = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           iss_valid,
  output logic                           iss_ready,
  input  logic [NUM_RD_PORTS*5-1:0]      iss_rs_addr,
  input  logic [NUM_RD_PORTS-1:0]        iss_rs_use,
  input  logic                           iss_has_rd,
  input  logic [4:0]                     iss_rd_addr,
  input  logic [NUM_BYP-1:0]             byp_valid,
  input  logic [NUM_BYP*5-1:0]           byp_rd,
  input  logic [NUM_BYP-1:0]             byp_rdy,
  input  logic [NUM_BYP*XLEN-1:0]        byp_data,
  input  logic                           wb_valid,
  input  logic [4:0]                     wb_rd,
  input  logic [XLEN-1:0]                wb_data,
  input  logic                           flush,
  output logic [NUM_RD_PORTS-1:0]        rs_byp_valid,
  output logic [NUM_RD_PORTS*XLEN-1:0]   rs_byp_data
`ifdef HZD_PERF_CNT_EN
  ,
  output logic [31:0]                    stall_cnt,
  input  logic                           stall_clr
`endif
);
  logic [CNT_W-1:0] cnt [NUM_REGS];
  byp_src_t [NUM_BYP-1:0] byp;
  byp_src_t wb_src;
  logic [NUM_RD_PORTS-1:0] pv, ph;
  logic [NUM_RD_PORTS*XLEN-1:0] pd;
  logic waw, hazard, fire;
  always_comb begin
    for (int i = 0; i < NUM_BYP; i++)
      byp[i] = '{valid: byp_valid[i], rd: byp_rd[i*5 +: 5], rdy: byp_rdy[i],
                 data: MAX_XLEN'(byp_data[i*XLEN +: XLEN])};
  end
  assign wb_src = '{valid: wb_valid, rd: wb_rd, rdy: 1'b1, data: MAX_XLEN'(wb_data)};
  genvar p;
  generate
    for (p = 0; p < NUM_RD_PORTS; p++) begin : g_port
      hzd_byp_sel #(.XLEN(XLEN), .NUM_BYP(NUM_BYP)) u_sel (
        .rs       (iss_rs_addr[p*5 +: 5]),
        .use_rs   (iss_rs_use[p]),
        .cnt_nz   (cnt[iss_rs_addr[p*5 +: 5]] != '0),
        .byp      (byp),
        .wb       (wb_src),
        .fwd_valid(pv[p]),
        .fwd_data (pd[p*XLEN +: XLEN]),
        .hazard   (ph[p])
      );
    end
  endgenerate
  assign waw = iss_has_rd && iss_rd_addr != '0 && cnt[iss_rd_addr] == '1;
  assign hazard = |ph || waw;
  assign iss_ready = en && !hazard;
  assign fire = iss_valid && iss_ready;
  assign rs_byp_valid = en ? pv : '0;
  assign rs_byp_data = en ? pd : '0;
  // Issue into a saturated counter is impossible (WAW guard), so only the decrement needs a floor.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else if (en) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (flush || r == 0) cnt[r] <= '0;
        else if (fire && iss_has_rd && iss_rd_addr == r[4:0] && !(wb_valid && wb_rd == r[4:0]))
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (wb_valid && wb_rd == r[4:0] && !(fire && iss_has_rd && iss_rd_addr == r[4:0]) && cnt[r] != '0)
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end
`ifdef HZD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || stall_clr) stall_cnt <= '0;
    else if (en && iss_valid && !iss_ready) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_hzd_scoreboard.sv
// tb_hzd_scoreboard: directed vectors with a queue-based scoreboard checked by a separate monitor
module tb_hzd_scoreboard;
  localparam int XLEN = 32, NR = 2, NB = 3;
  logic clk = 1'b0, rst, en, iss_valid, iss_ready, iss_has_rd, wb_valid, flush;
  logic [NR*5-1:0] iss_rs_addr;
  logic [NR-1:0] iss_rs_use, rs_byp_valid;
  logic [4:0] iss_rd_addr, wb_rd;
  logic [NB-1:0] byp_valid, byp_rdy;
  logic [NB*5-1:0] byp_rd;
  logic [NB*XLEN-1:0] byp_data;
  logic [XLEN-1:0] wb_data;
  logic [NR*XLEN-1:0] rs_byp_data;
  logic [31:0] stall_cnt_obs;
`ifdef HZD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic stall_clr;
  assign stall_cnt_obs = stall_cnt;
`else
  assign stall_cnt_obs = '0;
`endif
  always #5 clk = ~clk;

  hzd_scoreboard #(.XLEN(XLEN), .NUM_RD_PORTS(NR), .NUM_BYP(NB), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs_addr(iss_rs_addr), .iss_rs_use(iss_rs_use), .iss_has_rd(iss_has_rd),
    .iss_rd_addr(iss_rd_addr), .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_rdy(byp_rdy),
    .byp_data(byp_data), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .rs_byp_valid(rs_byp_valid), .rs_byp_data(rs_byp_data)
`ifdef HZD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .stall_clr(stall_clr)
`endif
  );

  typedef struct {
    string name;
    logic rdy;
    logic [NR-1:0] bv;
    logic [NR*XLEN-1:0] bd;
    logic chk_stall;
    logic [31:0] stall;
  } exp_t;
  exp_t q[$];
  int n_vec = 0, n_bad = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (iss_ready !== e.rdy || rs_byp_valid !== e.bv || rs_byp_data !== e.bd) begin
        n_bad++;
        $display("FAIL %s: got ready=%b bv=%b data=%h, want ready=%b bv=%b data=%h",
                 e.name, iss_ready, rs_byp_valid, rs_byp_data, e.rdy, e.bv, e.bd);
      end
`ifdef HZD_PERF_CNT_EN
      if (e.chk_stall && stall_cnt_obs !== e.stall) begin
        n_bad++;
        $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt_obs, e.stall);
      end
`endif
    end
  end

  task automatic idle();
    en = 1'b1; iss_valid = 0; iss_rs_addr = '0; iss_rs_use = '0; iss_has_rd = 0; iss_rd_addr = '0;
    byp_valid = '0; byp_rd = '0; byp_rdy = '0; byp_data = '0; wb_valid = 0; wb_rd = '0;
    wb_data = '0; flush = 0;
`ifdef HZD_PERF_CNT_EN
    stall_clr = 0;
`endif
  endtask

  task automatic set_byp(int i, logic [4:0] rd, logic r, logic [31:0] d);
    byp_valid[i] = 1'b1; byp_rd[i*5 +: 5] = rd; byp_rdy[i] = r; byp_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic rs(int prt, logic [4:0] a);
    iss_valid = 1'b1; iss_rs_use[prt] = 1'b1; iss_rs_addr[prt*5 +: 5] = a;
  endtask

  task automatic wr(logic [4:0] a);
    iss_valid = 1'b1; iss_has_rd = 1'b1; iss_rd_addr = a;
  endtask

  task automatic expect_(string n, logic r, logic [1:0] bv, logic [31:0] d1, logic [31:0] d0,
                         logic cs = 1'b0, logic [31:0] st = '0);
    exp_t e;
    e.name = n; e.rdy = r; e.bv = bv; e.bd = {d1, d0}; e.chk_stall = cs; e.stall = st;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    idle(); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(); rs(0, 5); expect_("reset_idle", 1, 2'b00, 0, 0, 1, 0);
    idle(); wr(5); expect_("issue_rd5", 1, 2'b00, 0, 0);
    idle(); rs(0, 5); expect_("raw_pending5", 0, 2'b00, 0, 0);
    idle(); rs(0, 5); wb_valid = 1; wb_rd = 5; wb_data = 32'h55; expect_("wb_fwd5", 1, 2'b01, 0, 32'h55);
    idle(); rs(0, 5); expect_("cleared5", 1, 2'b00, 0, 0);
    idle(); rs(1, 7); set_byp(0, 7, 1, 32'hDEAD); set_byp(1, 7, 1, 32'hBEEF);
    expect_("youngest_wins", 1, 2'b10, 32'hDEAD, 0);
    idle(); rs(0, 3); set_byp(0, 3, 0, 32'h111); set_byp(2, 3, 1, 32'h333);
    expect_("load_not_ready", 0, 2'b00, 0, 0);
    idle(); rs(0, 3); set_byp(0, 3, 1, 32'h111); set_byp(2, 3, 1, 32'h333);
    expect_("load_ready", 1, 2'b01, 0, 32'h111);
    for (int k = 0; k < 3; k++) begin idle(); wr(9); expect_("fill9", 1, 2'b00, 0, 0); end
    idle(); wr(9); expect_("waw_full9", 0, 2'b00, 0, 0);
    idle(); wb_valid = 1; wb_rd = 9; expect_("wb9_only", 1, 2'b00, 0, 0);
    idle(); wr(9); wb_valid = 1; wb_rd = 9; expect_("issue_wb9_same", 1, 2'b00, 0, 0);
    idle(); wr(9); expect_("issue9_to3", 1, 2'b00, 0, 0);
    idle(); wr(9); expect_("waw_full9_again", 0, 2'b00, 0, 0);
    idle(); wr(4); flush = 1; expect_("flush_issue4", 1, 2'b00, 0, 0);
    idle(); wr(9); expect_("post_flush9", 1, 2'b00, 0, 0);
    idle(); rs(0, 4); expect_("flush_kept4_zero", 1, 2'b00, 0, 0);
    idle(); rs(0, 9); expect_("pending9", 0, 2'b00, 0, 0);
    idle(); rs(0, 0); rs(1, 0); wr(0); set_byp(0, 0, 0, 32'h77); wb_valid = 1; wb_rd = 0;
    wb_data = 32'h88; expect_("x0_never", 1, 2'b00, 0, 0);
    idle(); en = 0; rs(0, 9); wb_valid = 1; wb_rd = 9; wb_data = 32'h99;
    expect_("en_low", 0, 2'b00, 0, 0);
    idle(); rs(0, 9); expect_("en_low_held9", 0, 2'b00, 0, 0);
    idle(); rst = 1; @(posedge clk); #1 rst = 0;
    idle(); rs(0, 9); expect_("after_rst9", 1, 2'b00, 0, 0, 1, 0);
    idle(); wr(9); expect_("perf_issue9", 1, 2'b00, 0, 0);
    for (int k = 0; k < 5; k++) begin idle(); rs(0, 9); expect_("perf_stall", 0, 2'b00, 0, 0); end
    idle(); expect_("stall_cnt5", 1, 2'b00, 0, 0, 1, 5);
    idle();
`ifdef HZD_PERF_CNT_EN
    stall_clr = 1;
`endif
    expect_("stall_clr_req", 1, 2'b00, 0, 0, 1, 5);
    idle(); expect_("stall_cleared", 1, 2'b00, 0, 0, 1, 0);
    @(posedge clk); #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
